// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the muldiv_seq slow-path unit: default operand
// width and the sequencer state encoding.
package muldiv_seq_pkg;

  localparam int unsigned L = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring shift-subtract divide.
// Purely combinational: the parent registers hi/lo every RUN cycle.
module muldiv_step #(
  parameter int unsigned l = 16
) (
  input  logic         op,
  input  logic [l-1:0] hi,
  input  logic [l-1:0] lo,
  input  logic [l-1:0] m,
  output logic [l-1:0] hi_nxt,
  output logic [l-1:0] lo_nxt
);

  logic [l:0]   s;
  logic [l+1:0] t;

  // Multiply adds m when the outgoing low bit is set, then shifts {carry,hi,lo}
  // right. Divide trial-subtracts m from the partial remainder shifted left.
  always_comb begin
    s      = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    t      = {1'b0, hi, lo[l-1]} - {2'b00, m};
    hi_nxt = hi;
    lo_nxt = lo;
    if (!op) begin
      hi_nxt = s[l:1];
      lo_nxt = {s[0], lo[l-1:1]};
    end else if (t[l+1:l] == 2'b00) begin
      // Top bit is the borrow; bit l stays clear because hi < m always holds.
      hi_nxt = t[l-1:0];
      lo_nxt = {lo[l-2:0], 1'b1};
    end else begin
      hi_nxt = {hi[l-2:0], lo[l-1]};
      lo_nxt = {lo[l-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multiply/divide sequencer with start/done handshake.
//
//   state | meaning
//   IDLE  | ready=1, waiting for start; result registers hold last result
//   RUN   | one multiply/divide step per clock, cnt = step index
//   DONE  | done=1 for this single cycle, result valid on hi/lo/dz
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned l = L
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         op,
  input  logic [l-1:0] a,
  input  logic [l-1:0] b,
  output logic         ready,
  output logic         done,
  output logic [l-1:0] hi,
  output logic [l-1:0] lo,
  output logic         dz
);

  localparam int unsigned CW = (l > 1) ? $clog2(l) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(l - 1);

  state_t        state, state_nxt;
  logic          op_r;
  logic [l-1:0]  m_r;
  logic [l-1:0]  hi_r, lo_r;
  logic [l-1:0]  hi_step, lo_step;
  logic [CW-1:0] cnt;
  logic          dz_r;
  logic          accept;
  logic          div0;

  assign accept = (state == IDLE) && start;
  assign div0   = op && (b == '0);

  assign ready = (state == IDLE);
  assign done  = (state == DONE);
  assign hi    = hi_r;
  assign lo    = lo_r;
  assign dz    = dz_r;

  muldiv_step #(.l(l)) u_step (
    .op     (op_r),
    .hi     (hi_r),
    .lo     (lo_r),
    .m      (m_r),
    .hi_nxt (hi_step),
    .lo_nxt (lo_step)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; divide by zero skips RUN entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = div0 ? DONE : RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept, iteration during RUN, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r <= 1'b0;
      m_r  <= '0;
      hi_r <= '0;
      lo_r <= '0;
      cnt  <= '0;
      dz_r <= 1'b0;
    end else if (accept) begin
      op_r <= op;
      m_r  <= b;
      cnt  <= '0;
      if (div0) begin
        hi_r <= a;
        lo_r <= '1;
        dz_r <= 1'b1;
      end else begin
        hi_r <= '0;
        lo_r <= a;
        dz_r <= 1'b0;
      end
    end else if (state == RUN) begin
      hi_r <= hi_step;
      lo_r <= lo_step;
      cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule
